// File: rtl/ov5640_sccb_slave.sv
// SCCB responder that models the OV5640 control port. It oversamples sclk/sdat on sysclk,
// decodes transactions, keeps a local register file and answers reads.
//  IDLE      | bus free          DEVID     | shifting device byte
//  DEVID_ACK | ack after ID      ADDR_H    | shifting ptr[15:8]
//  ADDRH_ACK | ack after ADDR_H  ADDR_L    | shifting ptr[7:0]
//  ADDRL_ACK | ack after ADDR_L  WDATA     | shifting write byte
//  WDATA_ACK | ack after data    RDATA     | driving read byte
//  RDATA_ACK | master ack/nack   WAIT_STOP | ignore bus until STOP/START
module ov5640_sccb_slave #(
    parameter logic [6:0]  DEV_ID   = 7'h3C,
    parameter int unsigned AW       = 8,
    parameter bit          ACK_EN   = 1'b1,
    parameter logic [7:0]  CHIPID_H = 8'h56,
    parameter logic [7:0]  CHIPID_L = 8'h40
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        cmos_sclk,
    inout  wire         cmos_sdat,
    output logic        busy,
    output logic        reg_wr_valid,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data
);

    typedef enum logic [3:0] {
        IDLE, DEVID, DEVID_ACK, ADDR_H, ADDRH_ACK, ADDR_L, ADDRL_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam int          DEPTH      = 1 << AW;
    localparam logic [15:0] CHIPID_H_A = 16'h300A;
    localparam logic [15:0] CHIPID_L_A = 16'h300B;

    logic sclk_s1_q, sclk_s2_q, sclk_p_q;
    logic sdat_s1_q, sdat_s2_q, sdat_p_q;
    logic sclk_rise, sclk_fall, start_det, stop_det, is_chipid;
    logic [7:0] rx_byte, rd_byte;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] ptr_q, ptr_d;
    logic        sdat_oe_q, sdat_oe_d;
    logic        reg_wr_valid_q, reg_wr_valid_d;
    logic [15:0] reg_wr_addr_q, reg_wr_addr_d;
    logic [7:0]  reg_wr_data_q, reg_wr_data_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];

    assign cmos_sdat = sdat_oe_q ? 1'b0 : 1'bz;

    // Synchronisers idle high so reset release never fakes a START/STOP
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b1;
            sclk_s2_q <= 1'b1;
            sclk_p_q  <= 1'b1;
            sdat_s1_q <= 1'b1;
            sdat_s2_q <= 1'b1;
            sdat_p_q  <= 1'b1;
        end else begin
            sclk_s1_q <= cmos_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_p_q  <= sclk_s2_q;
            sdat_s1_q <= cmos_sdat;
            sdat_s2_q <= sdat_s1_q;
            sdat_p_q  <= sdat_s2_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_p_q;
    assign sclk_fall = ~sclk_s2_q & sclk_p_q;
    assign start_det = sclk_s2_q & sclk_p_q & sdat_p_q & ~sdat_s2_q;
    assign stop_det  = sclk_s2_q & sclk_p_q & ~sdat_p_q & sdat_s2_q;
    assign rx_byte   = {shreg_q[6:0], sdat_s2_q};
    assign is_chipid = (ptr_q == CHIPID_H_A) || (ptr_q == CHIPID_L_A);
    assign rd_byte   = (ptr_q == CHIPID_H_A) ? CHIPID_H :
                       (ptr_q == CHIPID_L_A) ? CHIPID_L : mem_q[ptr_q[AW-1:0]];

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        tx_d           = tx_q;
        ptr_d          = ptr_q;
        sdat_oe_d      = sdat_oe_q;
        mem_d          = mem_q;
        reg_wr_valid_d = 1'b0;
        reg_wr_addr_d  = reg_wr_addr_q;
        reg_wr_data_d  = reg_wr_data_q;
        if (start_det) begin
            state_d   = DEVID;
            bit_cnt_d = 4'd0;
            sdat_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sdat_oe_d = 1'b0;
        end else if (sclk_rise) begin
            case (state_q)
                DEVID, ADDR_H, ADDR_L, WDATA: begin
                    if (bit_cnt_q < 4'd8) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                ADDR_H: ptr_d[15:8] = rx_byte;
                                ADDR_L: ptr_d[7:0]  = rx_byte;
                                WDATA: begin
                                    if (!is_chipid) begin
                                        mem_d[ptr_q[AW-1:0]] = rx_byte;
                                        reg_wr_valid_d       = 1'b1;
                                        reg_wr_addr_d        = ptr_q;
                                        reg_wr_data_d        = rx_byte;
                                    end
                                    ptr_d = ptr_q + 16'd1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                RDATA: if (bit_cnt_q < 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                RDATA_ACK: begin
                    shreg_d = rx_byte;
                    ptr_d   = ptr_q + 16'd1;
                end
                default: ;
            endcase
        end else if (sclk_fall) begin
            case (state_q)
                DEVID: if (bit_cnt_q == 4'd8) begin
                    if (shreg_q[7:1] == DEV_ID) begin
                        state_d   = DEVID_ACK;
                        sdat_oe_d = ACK_EN;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                ADDR_H: if (bit_cnt_q == 4'd8) begin state_d = ADDRH_ACK; sdat_oe_d = ACK_EN; end
                ADDR_L: if (bit_cnt_q == 4'd8) begin state_d = ADDRL_ACK; sdat_oe_d = ACK_EN; end
                WDATA:  if (bit_cnt_q == 4'd8) begin state_d = WDATA_ACK; sdat_oe_d = ACK_EN; end
                DEVID_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (shreg_q[0]) begin
                        state_d   = RDATA;
                        tx_d      = {rd_byte[6:0], 1'b0};
                        sdat_oe_d = ~rd_byte[7];
                    end else begin
                        state_d   = ADDR_H;
                        sdat_oe_d = 1'b0;
                    end
                end
                ADDRH_ACK: begin state_d = ADDR_L; bit_cnt_d = 4'd0; sdat_oe_d = 1'b0; end
                ADDRL_ACK, WDATA_ACK: begin state_d = WDATA; bit_cnt_d = 4'd0; sdat_oe_d = 1'b0; end
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = RDATA_ACK;
                        sdat_oe_d = 1'b0;
                    end else if (bit_cnt_q != 4'd0) begin
                        sdat_oe_d = ~tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (shreg_q[0]) begin
                        state_d = WAIT_STOP;
                    end else begin
                        state_d   = RDATA;
                        tx_d      = {rd_byte[6:0], 1'b0};
                        sdat_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 4'd0;
            shreg_q        <= 8'h00;
            tx_q           <= 8'h00;
            ptr_q          <= 16'h0000;
            sdat_oe_q      <= 1'b0;
            reg_wr_valid_q <= 1'b0;
            reg_wr_addr_q  <= 16'h0000;
            reg_wr_data_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            tx_q           <= tx_d;
            ptr_q          <= ptr_d;
            sdat_oe_q      <= sdat_oe_d;
            reg_wr_valid_q <= reg_wr_valid_d;
            reg_wr_addr_q  <= reg_wr_addr_d;
            reg_wr_data_q  <= reg_wr_data_d;
            mem_q          <= mem_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign reg_wr_valid = reg_wr_valid_q;
    assign reg_wr_addr  = reg_wr_addr_q;
    assign reg_wr_data  = reg_wr_data_q;

endmodule

// File: tb/tb_ov5640_sccb_slave.sv
// Directed bench for ov5640_sccb_slave: a behavioural SCCB master on an open-drain bus
// plus a table of write/readback vectors and hand-written corner-case sequences.
module tb_ov5640_sccb_slave;

    localparam int TS = 10;   // sysclk period
    localparam int Q  = 50;   // quarter SCCB bit time

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        m_sclk;
    logic        m_sdat_low;
    wire         cmos_sdat;
    logic        busy, reg_wr_valid;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;

    assign cmos_sdat = m_sdat_low ? 1'b0 : 1'bz;
    pullup (cmos_sdat);

    ov5640_sccb_slave dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .cmos_sclk    (m_sclk),
        .cmos_sdat    (cmos_sdat),
        .busy         (busy),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data)
    );

    always #(TS/2) sysclk = ~sysclk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    logic [15:0] last_addr = 16'h0;
    logic [7:0]  last_data = 8'h0;
    logic        slave_low_seen = 1'b0;

    always @(negedge sysclk) begin
        if (reg_wr_valid === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= reg_wr_addr;
            last_data <= reg_wr_data;
        end
        if (cmos_sdat === 1'b0 && !m_sdat_low) slave_low_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic m_start;
        m_sdat_low = 1'b0; #Q;
        m_sclk = 1'b1;     #Q;
        m_sdat_low = 1'b1; #Q;
        m_sclk = 1'b0;     #Q;
    endtask

    task automatic m_stop;
        m_sdat_low = 1'b1; #Q;
        m_sclk = 1'b1;     #Q;
        m_sdat_low = 1'b0; #Q;
        #(10*TS);
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sdat_low = ~b; #Q;
        m_sclk = 1'b1;   #Q;
        s = cmos_sdat;   #Q;
        m_sclk = 1'b0;   #Q;
    endtask

    // ack returns the sampled 9th bit: 0 means the slave acknowledged
    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_rbyte(output logic [7:0] d, input logic na);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(na, s);
    endtask

    task automatic wr_txn(input logic [15:0] a, input logic [7:0] d, output int acks);
        logic k;
        acks = 0;
        m_start;
        m_wbyte(8'h78, k);    acks += int'(!k);
        m_wbyte(a[15:8], k);  acks += int'(!k);
        m_wbyte(a[7:0], k);   acks += int'(!k);
        m_wbyte(d, k);        acks += int'(!k);
        m_stop;
    endtask

    task automatic set_ptr(input logic [15:0] a);
        logic k;
        m_start;
        m_wbyte(8'h78, k);
        m_wbyte(a[15:8], k);
        m_wbyte(a[7:0], k);
        m_stop;
    endtask

    task automatic rd1(output logic [7:0] d);
        logic k;
        m_start;
        m_wbyte(8'h79, k);
        m_rbyte(d, 1'b1);
        m_stop;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          exp_wr;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          acks, w0;
        logic        k, s;
        logic [7:0]  d0, d1;

        tbl[0] = '{16'h3008, 8'h82, 1, 8'h82};
        tbl[1] = '{16'h1234, 8'hA5, 1, 8'hA5};
        tbl[2] = '{16'h300A, 8'h11, 0, 8'h56};
        tbl[3] = '{16'h300B, 8'h22, 0, 8'h40};
        tbl[4] = '{16'hFFFF, 8'h5A, 1, 8'h5A};
        tbl[5] = '{16'h0000, 8'h3C, 1, 8'h3C};

        rst_n = 1'b0; m_sclk = 1'b1; m_sdat_low = 1'b0;
        #3;
        #(5*TS);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_valid", 32'(reg_wr_valid), 32'd0);
        check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_sdat_released", 32'(cmos_sdat), 32'd1);
        #(5*TS);
        rst_n = 1'b1;
        #(10*TS);

        // Write/readback vectors, including chip-ID drops and the aliasing top address
        for (int i = 0; i < 6; i++) begin
            w0 = wr_cnt;
            wr_txn(tbl[i].addr, tbl[i].data, acks);
            check($sformatf("tbl%0d_acks", i), 32'(acks), 32'd4);
            check($sformatf("tbl%0d_wr_pulses", i), 32'(wr_cnt - w0), 32'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_busy_after_stop", i), 32'(busy), 32'd0);
            if (tbl[i].exp_wr != 0) begin
                check($sformatf("tbl%0d_wr_addr", i), 32'(last_addr), 32'(tbl[i].addr));
                check($sformatf("tbl%0d_wr_data", i), 32'(last_data), 32'(tbl[i].data));
            end
            set_ptr(tbl[i].addr);
            rd1(d0);
            check($sformatf("tbl%0d_readback", i), 32'(d0), 32'(tbl[i].exp_rd));
        end

        // Busy during a transaction, and WAIT_STOP after a master NA
        m_start;
        m_wbyte(8'h78, k);
        check("busy_mid_txn", 32'(busy), 32'd1);
        m_wbyte(8'h30, k);
        m_wbyte(8'h08, k);
        m_stop;
        m_start;
        m_wbyte(8'h79, k);
        m_rbyte(d0, 1'b1);
        check("t2_read_0x3008", 32'(d0), 32'h82);
        check("t2_wait_stop_busy", 32'(busy), 32'd1);
        m_stop;
        check("t2_idle_after_stop", 32'(busy), 32'd0);

        // Sequential chip-ID read with master ACK then NA
        set_ptr(16'h300A);
        m_start;
        m_wbyte(8'h79, k);
        m_rbyte(d0, 1'b0);
        m_rbyte(d1, 1'b1);
        m_stop;
        check("t3_chipid_h", 32'(d0), 32'h56);
        check("t3_chipid_l", 32'(d1), 32'h40);

        // Burst write auto-increments the pointer, burst read follows it
        w0 = wr_cnt;
        m_start;
        m_wbyte(8'h78, k); m_wbyte(8'h00, k); m_wbyte(8'h10, k);
        m_wbyte(8'h11, k); m_wbyte(8'h22, k);
        m_stop;
        check("burst_wr_pulses", 32'(wr_cnt - w0), 32'd2);
        check("burst_last_addr", 32'(last_addr), 32'h0011);
        check("burst_last_data", 32'(last_data), 32'h22);
        set_ptr(16'h0010);
        m_start;
        m_wbyte(8'h79, k);
        m_rbyte(d0, 1'b0);
        m_rbyte(d1, 1'b1);
        m_stop;
        check("burst_rd0", 32'(d0), 32'h11);
        check("burst_rd1", 32'(d1), 32'h22);

        // Pointer wraps 0xFFFF->0x0000 and persists into an address-less read
        wr_txn(16'hFFFF, 8'hAB, acks);
        rd1(d0);
        check("wrap_read_idx0", 32'(d0), 32'h3C);
        // A dropped chip-ID write still advances the pointer
        wr_txn(16'h300A, 8'h99, acks);
        rd1(d0);
        check("chipid_drop_inc", 32'(d0), 32'h40);

        // Foreign device ID: never driven, no write
        w0 = wr_cnt;
        slave_low_seen = 1'b0;
        m_start;
        m_wbyte(8'h42, k);
        check("t4_nack_id", 32'(k), 32'd1);
        m_wbyte(8'h30, k); m_wbyte(8'h08, k); m_wbyte(8'h99, k);
        m_stop;
        check("t4_never_driven", 32'(slave_low_seen), 32'd0);
        check("t4_no_write", 32'(wr_cnt - w0), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // STOP after 5 data bits discards the byte
        w0 = wr_cnt;
        m_start;
        m_wbyte(8'h78, k); m_wbyte(8'h30, k); m_wbyte(8'h08, k);
        for (int i = 0; i < 5; i++) m_bit(1'b1, s);
        m_stop;
        check("t5_no_write", 32'(wr_cnt - w0), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        w0 = wr_cnt;
        wr_txn(16'h0055, 8'h77, acks);
        check("t5_next_acks", 32'(acks), 32'd4);
        check("t5_next_pulse", 32'(wr_cnt - w0), 32'd1);
        check("t5_next_addr", 32'(last_addr), 32'h0055);
        check("t5_next_data", 32'(last_data), 32'h77);

        // Reset while the slave drives bit 6 (=0) of 0xA5
        set_ptr(16'h1234);
        m_start;
        m_wbyte(8'h79, k);
        m_bit(1'b1, s);
        check("t6_bit7", 32'(s), 32'd1);
        m_sdat_low = 1'b0;
        #Q;
        check("t6_slave_driving", 32'(cmos_sdat), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_sdat_released", 32'(cmos_sdat), 32'd1);
        check("t6_busy_cleared", 32'(busy), 32'd0);
        #(Q-1);
        m_sclk = 1'b1;
        #Q;
        rst_n = 1'b1;
        #(10*TS);
        set_ptr(16'h1234);
        rd1(d0);
        check("t6_regfile_cleared_1234", 32'(d0), 32'h00);
        set_ptr(16'h3008);
        rd1(d0);
        check("t6_regfile_cleared_3008", 32'(d0), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
